// File: rtl/tmds_lane_gearbox_if.sv
// -----------------------------------------------------------------------------
// tmds_lane_gearbox_if
// Word-side valid/ready handshake feeding the TMDS lane gearbox.
//   s_data  : TMDS word, bit 0 transmitted first
//   s_valid : s_data is valid this cycle
//   s_ready : gearbox buffer can accept a word this cycle
// master = word producer (encoder side), slave = gearbox.
// -----------------------------------------------------------------------------
interface tmds_lane_gearbox_if #(
  parameter int WORD_W = 10
) ();
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/tmds_lane_gearbox.sv
// -----------------------------------------------------------------------------
// tmds_lane_gearbox
// Single-lane 10:2 transmit gearbox for the HDMI TX path. Everything runs on
// the fast serial-side clock. Each 10-bit TMDS word is shifted out as five
// 2-bit slices, LSB first, one slice per cycle, to a DDR output stage.
// A 2-entry FIFO decouples the word producer; when it runs dry an idle
// control symbol is substituted. A bitslip pulse stalls the word phase by
// one slot for lane alignment.
//
// Ports:
//   hclkin        in   fast clock, all logic on the rising edge
//   reset         in   synchronous, active-high
//   s             if   word handshake (s_data / s_valid / s_ready)
//   bitslip       in   single-cycle pulse, holds phase and slice one cycle
//   q             out  current slice, q[0] earlier in time
//   word_start    out  high while q carries bits [1:0] of a word
//   underflow     out  one-cycle pulse during phase 0 of an inserted idle word
//   underflow_cnt out  saturating count of inserted idle words
// -----------------------------------------------------------------------------
module tmds_lane_gearbox #(
  parameter int                 WORD_W    = 10,  // must equal 5 * LANE_W
  parameter int                 LANE_W    = 2,
  parameter logic [WORD_W-1:0]  IDLE_WORD = 10'b1101010100
) (
  input  logic                  hclkin,
  input  logic                  reset,
  tmds_lane_gearbox_if.slave    s,
  input  logic                  bitslip,
  output logic [LANE_W-1:0]     q,
  output logic                  word_start,
  output logic                  underflow,
  output logic [15:0]           underflow_cnt
);

  localparam int               SLICES     = WORD_W / LANE_W;
  localparam int               PH_W       = $clog2(SLICES);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(SLICES - 1);

  // Word phase and output shift register
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WORD_W-1:0] sh_q, sh_d;

  // 2-entry FIFO
  logic [WORD_W-1:0] mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count_q, count_d;

  logic              primed;
  logic              push, pop, load, starve;

  // ---------------------------------------------------------------------------
  // Output / handshake decode
  // ---------------------------------------------------------------------------
  assign s.s_ready = (count_q < 2'd2) && !reset;
  assign q         = sh_q[LANE_W-1:0];

  assign push   = s.s_valid && s.s_ready;
  // bitslip outranks the load, so a slip on the last phase delays the load.
  assign load   = !bitslip && (phase_q == LAST_PHASE);
  assign pop    = load && (count_q != 2'd0);
  // Idle insertion only counts once real traffic has been seen.
  assign starve = load && (count_q == 2'd0) && primed;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    phase_d = phase_q;
    sh_d    = sh_q;
    count_d = count_q;

    if (bitslip) begin
      phase_d = phase_q;
      sh_d    = sh_q;
    end else if (phase_q == LAST_PHASE) begin
      phase_d = '0;
      sh_d    = pop ? mem[rd_ptr] : IDLE_WORD;
    end else begin
      phase_d = phase_q + PH_W'(1);
      sh_d    = sh_q >> LANE_W;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;  // idle, or push+pop at count 1
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclkin) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      phase_q       <= LAST_PHASE;  // first cycle after release is a load
      sh_q          <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count_q       <= 2'd0;
      primed        <= 1'b0;
      word_start    <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= 16'd0;
    end else begin
      phase_q    <= phase_d;
      sh_q       <= sh_d;
      count_q    <= count_d;
      word_start <= (phase_d == '0);
      underflow  <= starve;
      if (push) begin
        wr_ptr <= ~wr_ptr;
        primed <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (starve && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and count alone
  // decide which entries are valid, so resetting the array buys nothing.
  always_ff @(posedge hclkin) begin
    if (push) mem[wr_ptr] <= s.s_data;
  end

endmodule

// File: tb/tb_tmds_lane_gearbox.sv
// -----------------------------------------------------------------------------
// tb_tmds_lane_gearbox
// Directed bench for tmds_lane_gearbox. Inputs change on the falling edge,
// outputs are compared on the falling edge after each rising edge. Expected
// slices come from the words themselves, taken LSB first.
// -----------------------------------------------------------------------------
module tb_tmds_lane_gearbox;

  localparam logic [9:0] IDLE = 10'b1101010100;

  logic        clk;
  logic        reset;
  logic        bitslip;
  logic [1:0]  q;
  logic        word_start;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int          n_checks;
  int          n_errors;
  int          cyc;
  logic [15:0] exp_cnt;

  tmds_lane_gearbox_if bus ();

  tmds_lane_gearbox dut (
    .hclkin        (clk),
    .reset         (reset),
    .s             (bus),
    .bitslip       (bitslip),
    .q             (q),
    .word_start    (word_start),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] slice(input logic [9:0] w, input int k);
    return w[2*k +: 2];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // One clock, then compare slice, word_start, underflow and the count.
  task automatic tick_check(input logic [1:0] eq, input logic ews, input logic euf);
    tick();
    if (euf && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    check($sformatf("q@%0d", cyc),          16'(q),          16'(eq));
    check($sformatf("word_start@%0d", cyc), 16'(word_start), 16'(ews));
    check($sformatf("underflow@%0d", cyc),  16'(underflow),  16'(euf));
    check($sformatf("uf_cnt@%0d", cyc),     underflow_cnt,   exp_cnt);
  endtask

  // Slices k0..k1 of word w; uf0 marks phase 0 as an inserted idle.
  task automatic word_ticks(input logic [9:0] w, input int k0, input int k1, input logic uf0);
    for (int k = k0; k <= k1; k++)
      tick_check(slice(w, k), k == 0, (k == 0) && uf0);
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check(tag, 16'(bus.s_ready), 16'(exp));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q"},          16'(q),          16'h0);
    check({tag, "_word_start"}, 16'(word_start), 16'h0);
    check({tag, "_underflow"},  16'(underflow),  16'h0);
    check({tag, "_uf_cnt"},     underflow_cnt,   16'h0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    exp_cnt     = 16'd0;
    reset       = 1'b1;
    bitslip     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset
    @(negedge clk);
    tick();
    tick();
    check_reset_state("rst");
    check_ready("rst_s_ready", 1'b0);

    // Release with no input: idle words, silent (not primed)
    reset = 1'b0;
    cyc   = 0;
    check_ready("rel_s_ready", 1'b1);
    word_ticks(IDLE, 0, 4, 1'b0);                      // 1-5
    word_ticks(IDLE, 0, 2, 1'b0);                      // 6-8

    // Streaming 3FF, 000, 2AA; FIFO fills and s_ready stalls
    bus.s_valid = 1'b1; bus.s_data = 10'h3FF;
    check_ready("s_ready_c0", 1'b1);
    word_ticks(IDLE, 3, 3, 1'b0);                      // 9: push 3FF
    bus.s_data = 10'h000;
    check_ready("s_ready_c1", 1'b1);
    word_ticks(IDLE, 4, 4, 1'b0);                      // 10: push 000
    bus.s_data = 10'h2AA;
    check_ready("s_ready_full", 1'b0);
    word_ticks(10'h3FF, 0, 0, 1'b0);                   // 11: pop 3FF
    check_ready("s_ready_after_pop", 1'b1);
    word_ticks(10'h3FF, 1, 1, 1'b0);                   // 12: push 2AA
    bus.s_valid = 1'b0;
    word_ticks(10'h3FF, 2, 4, 1'b0);                   // 13-15
    word_ticks(10'h000, 0, 4, 1'b0);                   // 16-20
    word_ticks(10'h2AA, 0, 2, 1'b0);                   // 21-23

    // Single word 155, then starvation: one underflow pulse per idle word
    bus.s_valid = 1'b1; bus.s_data = 10'h155;
    word_ticks(10'h2AA, 3, 3, 1'b0);                   // 24: push 155
    bus.s_valid = 1'b0;
    word_ticks(10'h2AA, 4, 4, 1'b0);                   // 25
    word_ticks(10'h155, 0, 4, 1'b0);                   // 26-30
    word_ticks(IDLE, 0, 4, 1'b1);                      // 31-35 cnt 1
    word_ticks(IDLE, 0, 4, 1'b1);                      // 36-40 cnt 2
    word_ticks(IDLE, 0, 0, 1'b1);                      // 41    cnt 3
    check("uf_cnt_three", underflow_cnt, 16'd3);

    // Bitslip at phase 2 of 1110010011: slice 01 repeats
    bus.s_valid = 1'b1; bus.s_data = 10'b1110010011;
    word_ticks(IDLE, 1, 1, 1'b0);                      // 42: push
    bus.s_valid = 1'b0;
    word_ticks(IDLE, 2, 4, 1'b0);                      // 43-45
    word_ticks(10'b1110010011, 0, 2, 1'b0);            // 46-48: 11,00,01
    bitslip = 1'b1;
    tick_check(2'b01, 1'b0, 1'b0);                     // 49: repeat 01
    bitslip = 1'b0;
    word_ticks(10'b1110010011, 3, 4, 1'b0);            // 50-51: 10,11
    word_ticks(IDLE, 0, 4, 1'b1);                      // 52-56: ws period 6

    // Bitslip on a load cycle delays the load by one
    bitslip = 1'b1;
    tick_check(slice(IDLE, 4), 1'b0, 1'b0);            // 57
    bitslip = 1'b0;
    word_ticks(IDLE, 0, 0, 1'b1);                      // 58

    // Push at count 1 coinciding with a pop: count stays 1, order kept
    bus.s_valid = 1'b1; bus.s_data = 10'h0F0;
    word_ticks(IDLE, 1, 1, 1'b0);                      // 59: push 0F0
    bus.s_valid = 1'b0;
    word_ticks(IDLE, 2, 4, 1'b0);                      // 60-62
    bus.s_valid = 1'b1; bus.s_data = 10'h30C;
    check_ready("s_ready_cnt1", 1'b1);
    word_ticks(10'h0F0, 0, 0, 1'b0);                   // 63: pop + push
    bus.s_valid = 1'b0;
    check_ready("s_ready_cnt_stays1", 1'b1);
    word_ticks(10'h0F0, 1, 4, 1'b0);                   // 64-67
    word_ticks(10'h30C, 0, 4, 1'b0);                   // 68-72
    word_ticks(IDLE, 0, 0, 1'b1);                      // 73: no duplicate

    // Preload the counter near full, then saturate
    force dut.underflow_cnt = 16'hFFFD;
    #1;
    release dut.underflow_cnt;
    exp_cnt = 16'hFFFD;
    word_ticks(IDLE, 1, 4, 1'b0);                      // 74-77
    word_ticks(IDLE, 0, 4, 1'b1);                      // 78-82 FFFE
    word_ticks(IDLE, 0, 4, 1'b1);                      // 83-87 FFFF
    word_ticks(IDLE, 0, 0, 1'b1);                      // 88 stays FFFF
    check("uf_cnt_saturated", underflow_cnt, 16'hFFFF);

    // Reset at phase 3 with two words buffered
    bus.s_valid = 1'b1; bus.s_data = 10'h111;
    word_ticks(IDLE, 1, 1, 1'b0);                      // 89
    bus.s_data = 10'h222;
    word_ticks(IDLE, 2, 2, 1'b0);                      // 90
    bus.s_valid = 1'b0;
    check_ready("s_ready_two_buffered", 1'b0);
    word_ticks(IDLE, 3, 3, 1'b0);                      // 91: phase 3
    reset = 1'b1;
    check_ready("s_ready_in_reset", 1'b0);
    tick();
    check_reset_state("midrst");
    reset   = 1'b0;
    exp_cnt = 16'd0;
    check_ready("s_ready_fifo_cleared", 1'b1);
    word_ticks(IDLE, 0, 4, 1'b0);                      // idle, unprimed
    word_ticks(IDLE, 0, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
